// File: rtl/txchar_pkg.sv
// txchar_pkg: shared constants and helpers for the fixed-character UART
// transmitter.
//   - Baud divisors for a 12 MHz system clock.
//   - Frame length, selected by the TXCHAR_PARITY_EN macro:
//       defined   -> 11-bit frame (start, 8 data, even parity, stop)
//       undefined -> 10-bit 8N1 frame
//   - State enum and frame builder used by uart_tx.
package txchar_pkg;

    // Clock cycles per bit at 12 MHz.
    localparam int B115200 = 104;
    localparam int B57600  = 208;
    localparam int B38400  = 313;
    localparam int B19200  = 625;
    localparam int B9600   = 1250;
    localparam int B4800   = 2500;
    localparam int B2400   = 5000;
    localparam int B1200   = 10000;
    localparam int B600    = 20000;
    localparam int B300    = 40000;

    localparam int FRAME_LEN_8N1 = 10;
    localparam int FRAME_LEN_8E1 = 11;

`ifdef TXCHAR_PARITY_EN
    localparam int FRAME_LEN = FRAME_LEN_8E1;
`else
    localparam int FRAME_LEN = FRAME_LEN_8N1;
`endif

    typedef enum logic {
        ST_IDLE,
        ST_TRANS
    } tx_state_e;

    // Frame as shifted out LSB first: start bit in bit 0, stop bit on top.
    function automatic logic [FRAME_LEN-1:0] build_frame(input logic [7:0] d);
`ifdef TXCHAR_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

    // Baud counter width; a divisor of 1 still needs a 1-bit counter.
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/txchar_if.sv
// txchar_if: byte handshake between a data source and uart_tx.
//   start : source requests transmission of data
//   data  : byte to send, sampled only when start and ready are both high
//   ready : transmitter can accept a byte on this clock edge
// Modports: master = data source, slave = transmitter.
interface txchar_if;
    logic       start;
    logic       ready;
    logic [7:0] data;

    modport master (output start, output data, input ready);
    modport slave  (input start, input data, output ready);
endinterface

// File: rtl/txchar_uart_tx.sv
// uart_tx: baud counter plus frame shift register.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : txchar_if slave (start/data in, ready out)
//   tx   : registered serial output, idle level 1
// Frame format depends on TXCHAR_PARITY_EN (see txchar_pkg).
// ready is high while idle and during the last cycle of the stop bit, so a
// source holding start high gets back-to-back frames with no idle gap.
module uart_tx
    import txchar_pkg::*;
#(
    parameter int BAUDDIV = B115200
) (
    input  logic     clk,
    input  logic     rst,
    txchar_if.slave  bus,
    output logic     tx
);

    localparam int             CW       = cnt_width(BAUDDIV);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(BAUDDIV - 1);
    localparam logic [3:0]     LAST_BIT = 4'(FRAME_LEN - 1);

    tx_state_e              state;
    logic [CW-1:0]          cnt;
    logic [3:0]             bit_idx;
    logic [FRAME_LEN-1:0]   shreg;

    logic                   wrap;
    logic                   last;
    logic                   load;
    logic [FRAME_LEN-1:0]   frame;

    assign wrap  = (cnt == CNT_MAX);
    assign last  = (bit_idx == LAST_BIT);
    assign frame = build_frame(bus.data);

    assign bus.ready = (state == ST_IDLE) || (state == ST_TRANS && wrap && last);
    assign load      = bus.ready && bus.start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '1;
            tx      <= 1'b1;
        end else if (load) begin
            // Counter cleared on every load so bit edges stay frame-aligned.
            state   <= ST_TRANS;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= frame;
            tx      <= frame[0];
        end else if (state == ST_TRANS) begin
            if (wrap) begin
                cnt <= '0;
                if (last) begin
                    // Stop bit done and no new byte offered: back to mark.
                    state   <= ST_IDLE;
                    bit_idx <= '0;
                    shreg   <= '1;
                    tx      <= 1'b1;
                end else begin
                    // tx takes the bit that becomes the new LSB.
                    shreg   <= {1'b1, shreg[FRAME_LEN-1:1]};
                    tx      <= shreg[1];
                    bit_idx <= bit_idx + 4'd1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/txchar.sv
// txchar: continuously transmits the constant character CHAR on an async
// serial line at BAUDDIV clock cycles per bit, starting on the first edge
// after reset release. Frames are back to back.
// Parameters:
//   BAUDDIV : clock cycles per bit (default 104 = 115200 baud at 12 MHz)
//   CHAR    : character sent in every frame (default 'A')
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   tx  : serial output, idle level 1
// Build option: TXCHAR_PARITY_EN adds an even-parity bit (11-bit frame).
module txchar
    import txchar_pkg::*;
#(
    parameter int         BAUDDIV = B115200,
    parameter logic [7:0] CHAR    = 8'h41
) (
    input  logic clk,
    input  logic rst,
    output logic tx
);

    txchar_if bus ();

    // Always requesting: the transmitter reloads CHAR at every frame end.
    assign bus.start = 1'b1;
    assign bus.data  = CHAR;

    uart_tx #(
        .BAUDDIV (BAUDDIV)
    ) u_uart_tx (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .tx  (tx)
    );

endmodule

// File: tb/tb_txchar.sv
// tb_txchar: directed bench for txchar and its uart_tx sub-module.
//   u0 : defaults (BAUDDIV 104, 'A'), own reset rst_a
//   u1 : BAUDDIV 4, CHAR 8'h55, reset rst_b
//   u2 : BAUDDIV 1, CHAR 8'h41, reset rst_b
//   u3 : bare uart_tx, BAUDDIV 2, handshake driven by the bench, reset rst_c
module tb_txchar;

`ifdef TXCHAR_PARITY_EN
    localparam int FL = 11;
    bit f41 [FL] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1};
    bit f55 [FL] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1};
    bit fa5 [FL] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
    localparam int FL = 10;
    bit f41 [FL] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};
    bit f55 [FL] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    bit fa5 [FL] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;
    logic tx0, tx1, tx2, tx3;

    int checks = 0;
    int errors = 0;
    int c0 = -1;   // frame-relative cycle index of u0
    int cb = -1;   // frame-relative cycle index of u1/u2

    always #5 clk = ~clk;

    txchar u0 (.clk(clk), .rst(rst_a), .tx(tx0));
    txchar #(.BAUDDIV(4), .CHAR(8'h55)) u1 (.clk(clk), .rst(rst_b), .tx(tx1));
    txchar #(.BAUDDIV(1), .CHAR(8'h41)) u2 (.clk(clk), .rst(rst_b), .tx(tx2));

    txchar_if hs_bus ();
    uart_tx #(.BAUDDIV(2)) u3 (.clk(clk), .rst(rst_c), .bus(hs_bus), .tx(tx3));

    task automatic chk(input string tag, input int cyc, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    // One clock; then check the free-running instances against the tables.
    task automatic step();
        logic ra, rb;
        ra = rst_a;
        rb = rst_b;
        @(posedge clk);
        #1;
        if (ra) c0 = -1; else c0++;
        if (rb) cb = -1; else cb++;
        chk("u0_tx", c0, tx0, ra ? 1'b1 : f41[(c0 / 104) % FL]);
        chk("u1_tx", cb, tx1, rb ? 1'b1 : f55[(cb / 4) % FL]);
        chk("u2_tx", cb, tx2, rb ? 1'b1 : f41[cb % FL]);
    endtask

    initial begin
        hs_bus.start = 1'b0;
        hs_bus.data  = 8'h00;

        // Reset held for 5 cycles: line stays at mark.
        repeat (5) step();
        chk("hs_rst_tx", 0, tx3, 1'b1);
        chk("hs_rst_ready", 0, hs_bus.ready, 1'b1);

        // Release: three back-to-back frames on u0, many on u1/u2.
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3 * FL * 104) step();

        // Advance u0 into data bit 3 (frame bit 4), then reset mid-frame.
        for (int i = 0; i < FL * 104 && (c0 % (FL * 104)) != 4 * 104 + 20; i++) step();
        chk("u0_in_bit3", c0, tx0, 1'b0);
        rst_a = 1'b1;
        step();
        chk("u0_mid_rst", c0, tx0, 1'b1);
        repeat (9) step();
        rst_a = 1'b0;
        step();
        chk("u0_restart", c0, tx0, 1'b0);
        repeat (110) step();

        // Single-cycle reset still restarts u1/u2 from a start bit.
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        repeat (FL * 4 * 2 + 5) step();

        // Bare uart_tx: nothing sent without start.
        rst_c = 1'b0;
        repeat (3) begin
            step();
            chk("hs_idle_tx", 0, tx3, 1'b1);
            chk("hs_idle_ready", 0, hs_bus.ready, 1'b1);
        end

        // Offer 8'hA5, then change data mid-frame: frame must stay A5.
        hs_bus.data  = 8'hA5;
        hs_bus.start = 1'b1;
        step();
        chk("hs_start_tx", 0, tx3, 1'b0);
        chk("hs_busy_ready", 0, hs_bus.ready, 1'b0);
        hs_bus.data = 8'h00;
        for (int k = 1; k < 2 * FL; k++) begin
            step();
            chk("hs_frame_tx", k, tx3, fa5[k / 2]);
            if (k == FL) chk("hs_mid_ready", k, hs_bus.ready, 1'b0);
            if (k == 2 * FL - 1) begin
                chk("hs_end_ready", k, hs_bus.ready, 1'b1);
                hs_bus.start = 1'b0;
            end
        end
        step();
        chk("hs_back_idle_tx", 0, tx3, 1'b1);
        chk("hs_back_idle_ready", 0, hs_bus.ready, 1'b1);
        step();
        chk("hs_stays_idle", 0, tx3, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/txchar.md
# txchar

Fixed-character serial transmitter for board bring-up. After reset release it continuously sends one constant 8-bit character over an 8N1 asynchronous serial line at a baud rate set by a clock-divider parameter. It sits at the top level of a UART demo design, driving the FPGA's TX pin directly, and needs no host interaction.

## Interface
- `BAUDDIV`, default 104: system clock cycles per serial bit (12 MHz / 115200 baud).
- `CHAR`, default 8'h41 ('A'): character transmitted in every frame.
- One clock `clk`; reset `rst` is synchronous and active-high.
- `clk`  input  1  system clock, 12 MHz nominal.
- `rst`  input  1  synchronous active-high reset.
- `tx`  output  1  serial line; idle/mark level is 1.

## Operation
- Frame format, 8N1:
  - start bit = 0,
  - then `CHAR[0]` through `CHAR[7]`, LSB first,
  - then stop bit = 1.
- Each bit lasts exactly `BAUDDIV` clock cycles, so one frame is `10*BAUDDIV` cycles.
- States:
  - IDLE: only while `rst` is high.
  - TRANS: bit index 0..9 and baud counter 0..`BAUDDIV`-1.
- Transitions:
  - IDLE -> TRANS on the first edge with `rst` low.
  - After the stop bit's last cycle, TRANS reloads the shift register and starts the next start bit with no idle gap between frames.
- Datapath:
  - 10-bit shift register loaded with {1, `CHAR`, 0}, shifted right.
  - `tx` is a register driven from the shift register LSB, with no combinational path from inputs.
- Baud counter:
  - Width is ceil(log2(`BAUDDIV`)).
  - It wraps to 0 at `BAUDDIV`-1.
  - The shift happens on that wrap.
  - The counter is cleared at every frame load so bit edges stay aligned.

## Timing
- Reset values: `tx` = 1, shift register = all ones, counters = 0, state = IDLE.
- Latency: `tx` falls to 0 (start bit) on the first rising edge at which `rst` is sampled low.
- Bit k of a frame occupies cycles [k*`BAUDDIV`, (k+1)*`BAUDDIV`-1] relative to the frame start.
- Frame n+1 starts exactly `10*BAUDDIV` cycles after frame n.
- Reset mid-frame: on the next edge `tx` = 1 and the frame is abandoned; nothing resumes.
- After release, a complete new frame starts from the start bit.
- Reset asserted for a single cycle still forces a full restart.
- `BAUDDIV` = 1 is legal: one cycle per bit.

## Configuration
- `TXCHAR_PARITY_EN` defined:
  - An even-parity bit (XOR of `CHAR`) is inserted between `CHAR[7]` and the stop bit.
  - The frame becomes 11 bits, i.e. `11*BAUDDIV` cycles.
- Macro undefined: plain 8N1, 10-bit frame as above.

## Structure
- Shared package `txchar_pkg`:
  - Baud divisor constants for a 12 MHz clock: B115200=104, B57600=208, B38400=313, B19200=625, B9600=1250, B4800=2500, B2400=5000, B1200=10000, B600=20000, B300=40000.
  - Frame length constants (10, or 11 with parity).
- One sub-module `uart_tx` is natural: baud counter plus shift register with a `start`/`ready` handshake.
  - `txchar` ties `start` high and feeds `CHAR`.
  - `uart_tx` shall latch data only when `ready` = 1 and `start` = 1.

## Test plan
- Reset sequence: hold `rst`=1 for 5 cycles -> `tx`=1 throughout. Release -> `tx`=0 from the next edge for exactly 104 cycles.
- Default parameters, 3 frames (3120 cycles): sample each bit centre (offset 52). Every frame must decode 0,1,0,0,0,0,0,1,0,1 (start, 0x41 LSB first, stop), and frames must be back-to-back.
- `CHAR`=8'h55, `BAUDDIV`=4: the bit stream must be 0,1,0,1,0,1,0,1,0,1 with each bit exactly 4 cycles, repeating every 40 cycles.
- Reset mid-frame: assert `rst` during data bit 3 -> `tx`=1 on the next edge. Release after 10 cycles -> a fresh start bit lasting a full 104 cycles.
- `TXCHAR_PARITY_EN` defined, `CHAR`=8'h41: the frame is 11 bits with parity bit 0 (even parity), repeating every 1144 cycles.
- `BAUDDIV`=1: `tx` toggles per cycle according to the frame pattern, with a 10-cycle period.
